// File: rtl/kamacore_ram.sv
// kamacore_ram: one byte-strobed write port and NUM_RD_PORTS registered read ports,
// zero-filled by an init sequencer after reset. Define KAMACORE_RAM_WR_FWD_EN for write-through collisions.
module kamacore_ram #(
  parameter int DATA_WIDTH     = 32,    // CPU_WIDTH
  parameter int MEM_ADDR_WIDTH = 10,    // ADDR_WIDTH
  parameter int RAM_SIZE       = 1024,
  parameter int NUM_RD_PORTS   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 init_done,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH/8-1:0]              wr_be,
  input  logic [MEM_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_err,
  input  logic [NUM_RD_PORTS-1:0]              rd_req,
  input  logic [NUM_RD_PORTS*MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS-1:0]              rd_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [MEM_ADDR_WIDTH:0] SIZE_W   = (MEM_ADDR_WIDTH + 1)'(RAM_SIZE);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(RAM_SIZE - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("kamacore_ram: DATA_WIDTH must be a multiple of 8");
  end
  if (RAM_SIZE < 1 || RAM_SIZE > (1 << MEM_ADDR_WIDTH)) begin : g_bad_ram_size
    $error("kamacore_ram: RAM_SIZE must be 1..2**MEM_ADDR_WIDTH");
  end
  if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > 4) begin : g_bad_ports
    $error("kamacore_ram: NUM_RD_PORTS must be 1..4");
  end

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic             r_init_done;
  logic             w_init_we;
  logic             w_ready;

  logic [DATA_WIDTH-1:0] r_mem [RAM_SIZE];

  logic             w_wr_in_range;
  logic             w_wr_fire;
  logic [IDX_W-1:0] w_wr_idx;

  logic [NUM_RD_PORTS-1:0]                 w_rd_acc;
  logic [NUM_RD_PORTS-1:0]                 w_rd_ok;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] w_rd_word;

  logic                                    r_wr_err;
  logic [NUM_RD_PORTS-1:0]                 r_rd_valid;
  logic [NUM_RD_PORTS-1:0]                 r_rd_err;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] r_rd_data;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_done <= (w_state_next == ST_READY);
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_init_we    = 1'b0;
    w_ready      = 1'b0;
    if (r_state == ST_INIT) begin
      w_init_we = 1'b1;
      if (r_cnt == LAST_IDX) w_state_next = ST_READY;
    end else begin
      w_ready = 1'b1;
    end
  end

  assign w_wr_in_range = ({1'b0, wr_addr} < SIZE_W);
  assign w_wr_fire     = w_ready & wr_en & w_wr_in_range;
  assign w_wr_idx      = wr_addr[IDX_W-1:0];

  // NOTE: the array has no reset so it maps onto BRAM; the init sequencer provides the defined state.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rd_acc  = '0;
    w_rd_ok   = '0;
    w_rd_word = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_rd_acc[p]  = w_ready & rd_req[p];
      w_rd_ok[p]   = ({1'b0, rd_addr[p*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]} < SIZE_W);
      w_rd_word[p] = r_mem[rd_addr[p*MEM_ADDR_WIDTH +: IDX_W]];
`ifdef KAMACORE_RAM_WR_FWD_EN
      // Lanes being written this cycle bypass the array; the rest keep old data.
      if (w_wr_fire && (rd_addr[p*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] == wr_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) w_rd_word[p][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_err   <= 1'b0;
      r_rd_valid <= '0;
      r_rd_err   <= '0;
      r_rd_data  <= '0;
    end else begin
      r_wr_err   <= w_ready & wr_en & ~w_wr_in_range;
      r_rd_valid <= w_rd_acc;
      r_rd_err   <= w_rd_acc & ~w_rd_ok;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (w_rd_acc[p]) r_rd_data[p] <= w_rd_ok[p] ? w_rd_word[p] : '0;
      end
    end
  end

  assign init_done = r_init_done;
  assign wr_err    = r_wr_err;
  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_kamacore_ram.sv
// Directed testbench for kamacore_ram: 16-word, 32-bit, 3 read ports, 5-bit addresses.
module tb_kamacore_ram;

  localparam int DW  = 32;
  localparam int MAW = 5;
  localparam int RS  = 16;
  localparam int NP  = 3;

`ifdef KAMACORE_RAM_WR_FWD_EN
  localparam logic [DW-1:0] EXP_COL  = 32'h1111_1111;
  localparam logic [DW-1:0] EXP_PART = 32'h1111_AAAA;
`else
  localparam logic [DW-1:0] EXP_COL  = 32'h2222_2222;
  localparam logic [DW-1:0] EXP_PART = 32'h1111_1111;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_done;
  logic              wr_en;
  logic [DW/8-1:0]   wr_be;
  logic [MAW-1:0]    wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_err;
  logic [NP-1:0]     rd_req;
  logic [NP*MAW-1:0] rd_addr;
  logic [NP-1:0]     rd_valid;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_err;

  int vectors     = 0;
  int miscompares = 0;

  kamacore_ram #(
    .DATA_WIDTH    (DW),
    .MEM_ADDR_WIDTH(MAW),
    .RAM_SIZE      (RS),
    .NUM_RD_PORTS  (NP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .wr_en    (wr_en),
    .wr_be    (wr_be),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_req  = '0;
    rd_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [MAW-1:0] a);
    rd_req[p]             = 1'b1;
    rd_addr[p*MAW +: MAW] = a;
  endtask

  task automatic set_wr(input logic [MAW-1:0] a, input logic [DW/8-1:0] be, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic test_reset();
    idle();
    @(negedge clk);
    vectors++;
    if ({init_done, wr_err, rd_valid, rd_err, rd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got init_done=%b wr_err=%b rd_valid=%b rd_err=%b rd_data=%h expected all zero",
               init_done, wr_err, rd_valid, rd_err, rd_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= RS; k++) begin
      @(negedge clk);
      vectors++;
      if (init_done !== (k == RS)) begin
        miscompares++;
        $display("FAIL init_length cycle %0d: got init_done=%b expected %b", k, init_done, (k == RS));
      end
    end
  endtask

  task automatic test_init_sweep();
    logic [NP-1:0] exp_v;
    for (int c = 0; c * NP < RS; c++) begin
      idle();
      exp_v = '0;
      for (int p = 0; p < NP; p++) begin
        if (c * NP + p < RS) begin
          set_rd(p, MAW'(c * NP + p));
          exp_v[p] = 1'b1;
        end
      end
      @(negedge clk);
      vectors++;
      if (rd_valid !== exp_v || rd_err !== '0) begin
        miscompares++;
        $display("FAIL sweep_valid cycle %0d: got valid=%b err=%b expected valid=%b err=000", c, rd_valid, rd_err, exp_v);
      end
      for (int p = 0; p < NP; p++) begin
        if (exp_v[p]) begin
          vectors++;
          if (port_data(p) !== '0) begin
            miscompares++;
            $display("FAIL sweep_data addr %0d: got %h expected 00000000", c * NP + p, port_data(p));
          end
        end
      end
    end
  endtask

  task automatic test_byte_strobes();
    idle();
    set_wr(5'd5, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    set_wr(5'd5, 4'h4, 32'h00AA_0000);
    @(negedge clk);
    idle();
    set_rd(0, 5'd5);
    @(negedge clk);
    vectors++;
    if (rd_valid[0] !== 1'b1 || rd_err[0] !== 1'b0 || port_data(0) !== 32'hDEAA_BEEF) begin
      miscompares++;
      $display("FAIL byte_strobe_read: got valid=%b err=%b data=%h expected 1 0 deaabeef", rd_valid[0], rd_err[0], port_data(0));
    end
    idle();
    @(negedge clk);
    vectors++;
    if (rd_valid !== '0 || port_data(0) !== 32'hDEAA_BEEF) begin
      miscompares++;
      $display("FAIL valid_pulse_hold: got valid=%b data=%h expected 000 deaabeef", rd_valid, port_data(0));
    end
  endtask

  task automatic test_multi_port();
    idle();
    set_wr(5'd5, 4'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    for (int p = 0; p < NP; p++) set_rd(p, 5'd5);
    @(negedge clk);
    vectors++;
    if (rd_valid !== '1 || rd_err !== '0 || wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_port_flags: got valid=%b err=%b wr_err=%b expected 111 000 0", rd_valid, rd_err, wr_err);
    end
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (port_data(p) !== 32'hDEAA_BEEF) begin
        miscompares++;
        $display("FAIL multi_port_data port %0d: got %h expected deaabeef", p, port_data(p));
      end
    end
  endtask

  task automatic test_collision();
    idle();
    set_wr(5'd7, 4'hF, 32'h2222_2222);
    @(negedge clk);
    set_wr(5'd7, 4'hF, 32'h1111_1111);
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    set_rd(2, 5'd6);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (port_data(p) !== EXP_COL) begin
        miscompares++;
        $display("FAIL collision_full port %0d: got %h expected %h", p, port_data(p), EXP_COL);
      end
    end
    vectors++;
    if (port_data(2) !== '0) begin
      miscompares++;
      $display("FAIL collision_other_addr: got %h expected 00000000", port_data(2));
    end
    idle();
    set_wr(5'd7, 4'b0011, 32'hAAAA_AAAA);
    set_rd(0, 5'd7);
    @(negedge clk);
    vectors++;
    if (port_data(0) !== EXP_PART) begin
      miscompares++;
      $display("FAIL collision_partial: got %h expected %h", port_data(0), EXP_PART);
    end
    idle();
    set_rd(0, 5'd7);
    @(negedge clk);
    vectors++;
    if (port_data(0) !== 32'h1111_AAAA) begin
      miscompares++;
      $display("FAIL write_latency: got %h expected 1111aaaa", port_data(0));
    end
  endtask

  task automatic test_out_of_range();
    idle();
    set_wr(5'd20, 4'hF, 32'h1234_5678);
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_err_pulse: got %b expected 1", wr_err);
    end
    set_wr(5'd15, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_err_clear_boundary: got %b expected 0", wr_err);
    end
    set_wr(5'd16, 4'hF, 32'h5555_5555);
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_err_addr16: got %b expected 1", wr_err);
    end
    idle();
    set_rd(0, 5'd4);
    set_rd(1, 5'd20);
    set_rd(2, 5'd15);
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b111 || rd_err !== 3'b010 || wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_read_flags: got valid=%b err=%b wr_err=%b expected 111 010 0", rd_valid, rd_err, wr_err);
    end
    vectors++;
    if (port_data(0) !== '0 || port_data(1) !== '0 || port_data(2) !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL oor_read_data: got %h %h %h expected 00000000 00000000 cafef00d", port_data(0), port_data(1), port_data(2));
    end
    idle();
    set_rd(0, 5'd16);
    set_rd(1, 5'd0);
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b011 || rd_err !== 3'b001 || port_data(0) !== '0 || port_data(1) !== '0) begin
      miscompares++;
      $display("FAIL oor_alias: got valid=%b err=%b d0=%h d1=%h expected 011 001 0 0", rd_valid, rd_err, port_data(0), port_data(1));
    end
  endtask

  task automatic test_reset_mid_init();
    idle();
    for (int p = 0; p < NP; p++) set_rd(p, 5'd15);
    set_wr(5'd20, 4'hF, 32'h1234_5678);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({init_done, wr_err, rd_valid, rd_err, rd_data} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_clear: got init_done=%b wr_err=%b rd_valid=%b rd_err=%b rd_data=%h expected all zero",
               init_done, wr_err, rd_valid, rd_err, rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    set_wr(5'd20, 4'hF, 32'h1234_5678);
    for (int p = 0; p < NP; p++) set_rd(p, (p == 0) ? 5'd2 : 5'd20);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (rd_valid !== '0 || rd_err !== '0 || wr_err !== 1'b0 || init_done !== 1'b0) begin
        miscompares++;
        $display("FAIL init_ignores_req cycle %0d: got valid=%b err=%b wr_err=%b init_done=%b expected all zero",
                 k, rd_valid, rd_err, wr_err, init_done);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int k = 1; k <= RS; k++) begin
      @(negedge clk);
      vectors++;
      if (init_done !== (k == RS) || rd_valid !== '0) begin
        miscompares++;
        $display("FAIL reinit_length cycle %0d: got init_done=%b valid=%b expected %b 000", k, init_done, rd_valid, (k == RS));
      end
      idle();
      if (k >= 6 && k < RS) begin
        set_wr(5'd3, 4'hF, 32'hFFFF_FFFF);
        set_rd(0, 5'd3);
      end
    end
    set_rd(0, 5'd3);
    set_rd(1, 5'd15);
    @(negedge clk);
    vectors++;
    if (rd_valid !== 3'b011 || rd_err !== '0 || port_data(0) !== '0 || port_data(1) !== '0) begin
      miscompares++;
      $display("FAIL post_reinit_read: got valid=%b err=%b d0=%h d1=%h expected 011 000 0 0", rd_valid, rd_err, port_data(0), port_data(1));
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_byte_strobes();
    test_multi_port();
    test_collision();
    test_out_of_range();
    test_reset_mid_init();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
